// File: rtl/register_file.sv
// Architectural register file for the decode stage: 32 x 32-bit entries,
// two combinational read ports (rB on port 1, rA on port 2) and one
// synchronous write port driven by writeback. Register 0 is ordinary
// storage. No write-to-read bypass: the pipeline forwards from WB
// outside this block.

module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32            // must equal 2**ADDR_W
) (
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2
);

    // Full address space is populated, so every index is legal.
    logic [DATA_W-1:0] mem [DEPTH];

    // Register state: a synchronous clear beats a same-edge write, and the
    // write lands on the edge.
    // NOTE: this memory is cleared on reset on purpose. Architectural state
    // must read zero after reset, so it cannot map onto a RAM macro without
    // a clear port. The loop over all entries makes the clear fan out in
    // parallel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: state is updated with <= so that every reader in the
                // same edge sees pre-edge values regardless of block order.
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read ports are plain muxes on the stored array. A pending write is not
    // visible until its edge.
    assign rd_data1 = mem[rd_addr1];
    assign rd_data2 = mem[rd_addr2];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file. It runs directed cases and then
// randomized cycles. A plain array model holds the expected contents.

module tb_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;

    int checks   = 0;
    int failures = 0;

    // Expected contents of every register
    logic [DATA_W-1:0] model [DEPTH];

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One rising edge: the model applies the edge rules, and the bench
    // resumes 1ns later so outputs have settled.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (wr_en) begin
            model[wr_addr] = wr_data;
        end
        #1;
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_both(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        rd_addr1 = a1; rd_addr2 = a2;
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr1 = '0; rd_addr2 = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = 'x;
        tick();
        rst = 1'b0;

        // Reset state: everything reads zero
        read_both(5'd0, 5'd31);
        check("reset_r0", rd_data1, 32'h0);
        check("reset_r31", rd_data2, 32'h0);

        // Reset clears a written value
        write_reg(5'd5, 32'hDEADBEEF);
        read_both(5'd5, 5'd5);
        check("pre_reset_r5", rd_data1, 32'hDEADBEEF);
        rst = 1'b1; tick(); rst = 1'b0;
        read_both(5'd5, 5'd5);
        check("reset_clear_p1", rd_data1, 32'h0);
        check("reset_clear_p2", rd_data2, 32'h0);

        // Basic write/read on both ports
        write_reg(5'd3, 32'h12345678);
        read_both(5'd3, 5'd3);
        check("wr3_p1", rd_data1, 32'h12345678);
        check("wr3_p2", rd_data2, 32'h12345678);
        write_reg(5'd31, 32'hFFFFFFFF);
        read_both(5'd31, 5'd30);
        check("wr31_p1", rd_data1, 32'hFFFFFFFF);
        check("r30_zero", rd_data2, 32'h0);

        // Write enable low
        wr_en = 1'b0; wr_addr = 5'd7; wr_data = 32'hAAAA5555;
        tick();
        read_both(5'd7, 5'd7);
        check("wen_low_r7", rd_data1, 32'h0);

        // Same-cycle read of the register being written: no bypass
        write_reg(5'd9, 32'h00000011);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000022;
        read_both(5'd0, 5'd9);
        check("no_bypass_pre", rd_data2, 32'h00000011);
        tick();
        wr_en = 1'b0;
        check("no_bypass_post", rd_data2, 32'h00000022);

        // Reset priority over a simultaneous write
        write_reg(5'd4, 32'h00000044);
        rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0BADF00D;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        read_both(5'd4, 5'd4);
        check("rst_prio_r4", rd_data1, 32'h0);

        // rst high between edges has no effect until the edge
        write_reg(5'd6, 32'hCAFE0006);
        rst = 1'b1;
        read_both(5'd6, 5'd6);
        check("rst_sync_hold", rd_data1, 32'hCAFE0006);
        rst = 1'b0;
        tick();
        read_both(5'd6, 5'd6);
        check("rst_released", rd_data2, 32'hCAFE0006);

        // Full sweep: 0x100+i everywhere, read with crossed addresses
        for (int i = 0; i < DEPTH; i++) write_reg(ADDR_W'(i), 32'h100 + i);
        for (int i = 0; i < DEPTH; i++) begin
            read_both(ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));
            check($sformatf("sweep_p1_r%0d", i), rd_data1, 32'h100 + i);
            check($sformatf("sweep_p2_r%0d", DEPTH - 1 - i), rd_data2,
                  32'h100 + (DEPTH - 1 - i));
        end

        // Randomized traffic against the model, before and after each edge
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 39) == 0);
            wr_en    = $urandom_range(0, 1);
            wr_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
            wr_data  = $urandom;
            rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr
                                                   : ADDR_W'($urandom_range(0, DEPTH - 1));
            rd_addr2 = ADDR_W'($urandom_range(0, DEPTH - 1));
            #1;
            check("rand_pre_p1", rd_data1, model[rd_addr1]);
            check("rand_pre_p2", rd_data2, model[rd_addr2]);
            tick();
            check("rand_post_p1", rd_data1, model[rd_addr1]);
            check("rand_post_p2", rd_data2, model[rd_addr2]);
        end
        rst = 1'b0; wr_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
